tile_map_writer: RTL and testbench
==================================

Name: tile_map_writer

Overview:
- Bus-side command engine that loads the 80x60 tile map read by the tile renderer.
- Replaces the renderer's hard-coded initial tile placement.
- Accepts CPU register writes (single tile, run fill, full-screen clear) and turns them into one-write-per-cycle commands on the tile map RAM write port.
- Clears the map to the blank tile after reset.

Parameters:
- NUM_TILES, 4800, tile map entries (80x60)
- NUM_IDS, 38, number of valid tile bitmap ids
- BLANK_ID, 37, id of the all-zero tile
- ADDR_W, 13, tile map address width
- ID_W, 6, tile id width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- writedata  in  16  bus write data
- write  in  1  bus write strobe
- read  in  1  bus read strobe
- chipselect  in  1  block select; write/read act only when high
- address  in  3  register select
- readdata  out  16  status: [15]=busy, [14]=overrun, [13]=0, [12:0]=cursor
- tm_we  out  1  tile map write enable
- tm_addr  out  ADDR_W  tile map write address
- tm_data  out  ID_W  tile map write data
- busy  out  1  engine running a CLEAR or FILL sequence

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset. Reset has priority over everything, including an in-progress FILL or CLEAR, which it aborts.
- Reset values:
  - tm_we=0, tm_addr=0, tm_data=BLANK_ID
  - cursor=0, fill_id=BLANK_ID, overrun=0
  - state=CLEAR, busy=1 on the first cycle after reset deasserts
- Registers, acting on chipselect&write:
  - 0 CURSOR: cursor<=writedata[12:0]; a value >=NUM_TILES loads 0.
  - 1 TILE: the cycle after the write, tm_we=1, tm_addr=cursor, tm_data=id. Then cursor<=cursor+1, wrapping NUM_TILES-1 -> 0.
  - 2 FILL_ID: fill_id<=id.
  - 3 FILL_COUNT: n=writedata[12:0], clamped to NUM_TILES.
    - n=0 is a no-op.
    - Otherwise enter FILL with remaining=n.
  - 4 CLEAR: enter CLEAR (any data).
  - 5 STATUS_CLR: overrun<=0.
  - 6 STRIDE: only with the optional feature; ignored otherwise.
  - 7: reserved, ignored.
- Tile id sanitising: any id written to TILE or FILL_ID that is >=NUM_IDS becomes BLANK_ID.
- States:
  - IDLE: accepts all registers.
  - FILL: each cycle issues tm_we=1, tm_addr=cursor, tm_data=fill_id, advances cursor with wrap, and decrements remaining. When the last write issues, go to IDLE. busy=0 on the following cycle.
  - CLEAR: writes BLANK_ID to addresses 0..NUM_TILES-1 in order, one per cycle. Takes exactly NUM_TILES cycles, then IDLE. Cursor is left at 0.
- Writes while busy:
  - Writes to addresses 0-4 and 6 are dropped and set overrun=1 (sticky).
  - Address 5 is always honoured.
  - A bus write and a FILL completion in the same cycle: the write still counts as busy (dropped).
- Latency: first tm_we is one cycle after the accepting bus write, for TILE, FILL and CLEAR alike. Bus writes never stall.
- Reads: readdata is registered and valid one cycle after chipselect&read. With no read, readdata holds its last value.
- tm_we is 0 in every cycle without an issued write. tm_addr and tm_data hold their last values.
- busy = (state != IDLE).

Optional Feature:
- Macro: TILE_FILL_STRIDE_EN.
- Enabled:
  - Address 6 loads stride<=writedata[6:0], range 1..80. 0 and >80 load 1. Reset value 1.
  - FILL advances cursor by stride, modulo NUM_TILES (subtract NUM_TILES when sum >=NUM_TILES). This draws vertical wall runs with stride 80.
  - TILE and CLEAR always step by 1.
- Disabled: no stride register; FILL steps by 1; address 6 writes are ignored (overrun still set if busy).

Test Plan:
- Reset 1 cycle, then run → tm_we high 4800 consecutive cycles, addr 0..4799, data 37; busy falls on the cycle after addr 4799; readdata cursor=0.
- CURSOR=4799, TILE=5, TILE=6 → writes (4799,5) then (0,6); cursor=1. TILE=50 → data 37.
- CURSOR=1227, FILL_ID=1, FILL_COUNT=12 → addrs 1227..1238 data 1 in 12 consecutive cycles; busy for 12 cycles; cursor=1239.
- During that fill, TILE=3 → no extra write; overrun=1 in readdata[14]; STATUS_CLR → overrun=0. FILL_COUNT=0 → no writes, busy stays 0.
- FILL_COUNT=100 from cursor 0, reset asserted at the 10th write → writes stop next cycle; CLEAR restarts from addr 0; overrun=0, cursor=0.
- TILE_FILL_STRIDE_EN defined: CURSOR=4720, STRIDE=80, FILL_ID=9, FILL_COUNT=3 → addrs 4720, 0, 80 data 9; cursor=160.

Source files
------------

// File: rtl/tile_map_writer_if.sv
// -----------------------------------------------------------------------------
// tile_map_writer_if
// Groups the CPU register bus and the tile map RAM write port of
// tile_map_writer into one bundle.
//
//   CPU bus   : writedata[15:0], write, read, chipselect, address[2:0]
//               readdata[15:0]  ([15]=busy, [14]=overrun, [13]=0, [12:0]=cursor)
//   Tile RAM  : tm_we, tm_addr[ADDR_W-1:0], tm_data[ID_W-1:0]
//   Status    : busy
//
// master : the CPU / environment side (drives the bus, observes the outputs)
// slave  : the tile_map_writer engine
// -----------------------------------------------------------------------------
interface tile_map_writer_if #(
    parameter int ADDR_W = 13,
    parameter int ID_W   = 6
);
    logic [15:0]       writedata;
    logic              write;
    logic              read;
    logic              chipselect;
    logic [2:0]        address;
    logic [15:0]       readdata;
    logic              tm_we;
    logic [ADDR_W-1:0] tm_addr;
    logic [ID_W-1:0]   tm_data;
    logic              busy;

    modport master (
        output writedata, write, read, chipselect, address,
        input  readdata, tm_we, tm_addr, tm_data, busy
    );

    modport slave (
        input  writedata, write, read, chipselect, address,
        output readdata, tm_we, tm_addr, tm_data, busy
    );
endinterface

// File: rtl/tile_map_writer.sv
// -----------------------------------------------------------------------------
// tile_map_writer
// Command engine that loads the 80x60 tile map used by the tile renderer.
// CPU register writes (single tile, run fill, full-screen clear) are turned
// into at most one write per cycle on the tile map RAM write port. After
// reset the whole map is cleared to the blank tile.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset (aborts any running sequence)
//   bus    : tile_map_writer_if.slave
//            writedata/write/read/chipselect/address in, readdata out,
//            tm_we/tm_addr/tm_data tile map write port, busy status
//
// Registers (address): 0 CURSOR, 1 TILE, 2 FILL_ID, 3 FILL_COUNT, 4 CLEAR,
//                      5 STATUS_CLR, 6 STRIDE (optional), 7 reserved.
//
// Optional feature macro: TILE_FILL_STRIDE_EN
//   When defined, register 6 sets the FILL cursor step (1..80).
//   When undefined, FILL always steps by 1 and register 6 is ignored.
//
// readdata packing assumes ADDR_W = 13 (busy, overrun, 0, cursor = 16 bits).
// -----------------------------------------------------------------------------
module tile_map_writer #(
    parameter int NUM_TILES = 4800,
    parameter int NUM_IDS   = 38,
    parameter int BLANK_ID  = 37,
    parameter int ADDR_W    = 13,
    parameter int ID_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    tile_map_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int SUM_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] TILES_W = ADDR_W'(NUM_TILES);
    localparam logic [ID_W-1:0]   BLANK_W = ID_W'(BLANK_ID);

    localparam logic [2:0] REG_CURSOR     = 3'd0;
    localparam logic [2:0] REG_TILE       = 3'd1;
    localparam logic [2:0] REG_FILL_ID    = 3'd2;
    localparam logic [2:0] REG_FILL_COUNT = 3'd3;
    localparam logic [2:0] REG_CLEAR      = 3'd4;
    localparam logic [2:0] REG_STATUS_CLR = 3'd5;
    localparam logic [2:0] REG_STRIDE     = 3'd6;
    localparam logic [2:0] REG_RESERVED   = 3'd7;

    // Out-of-range ids are replaced by the blank tile; the whole data word is
    // compared so that stray upper bits cannot alias onto a valid id.
    function automatic logic [ID_W-1:0] sanitize_id(input logic [15:0] data);
        return (data >= 16'(NUM_IDS)) ? BLANK_W : data[ID_W-1:0];
    endfunction

    // Cursor advance with a single conditional wrap; step never exceeds 80,
    // so one subtraction is enough to stay inside the map.
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] cur,
                                                  input logic [6:0]        step);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cur} + SUM_W'(step);
        return (sum >= SUM_W'(NUM_TILES)) ? ADDR_W'(sum - SUM_W'(NUM_TILES))
                                          : sum[ADDR_W-1:0];
    endfunction

    state_t            r_state,     w_state;
    logic [ADDR_W-1:0] r_cursor,    w_cursor;
    logic [ID_W-1:0]   r_fill_id,   w_fill_id;
    logic              r_overrun,   w_overrun;
    logic [ADDR_W-1:0] r_remaining, w_remaining;
    logic              r_tm_we,     w_tm_we;
    logic [ADDR_W-1:0] r_tm_addr,   w_tm_addr;
    logic [ID_W-1:0]   r_tm_data,   w_tm_data;
    logic [15:0]       r_readdata,  w_readdata;

    logic              w_busy;
    logic              w_bus_wr;
    logic              w_bus_rd;
    logic [ADDR_W-1:0] w_count_raw;
    logic [ADDR_W-1:0] w_count;
    logic [6:0]        w_fill_step;

`ifdef TILE_FILL_STRIDE_EN
    logic [6:0]        r_stride,    w_stride;
    logic [6:0]        w_stride_in;
    assign w_stride_in = bus.writedata[6:0];
    assign w_fill_step = r_stride;
`else
    assign w_fill_step = 7'd1;
`endif

    assign w_busy      = (r_state != ST_IDLE);
    assign w_bus_wr    = bus.chipselect & bus.write;
    assign w_bus_rd    = bus.chipselect & bus.read;
    assign w_count_raw = bus.writedata[ADDR_W-1:0];
    assign w_count     = (w_count_raw > TILES_W) ? TILES_W : w_count_raw;

    // Next-state, register updates and tile map write selection.
    always_comb begin
        w_state     = r_state;
        w_cursor    = r_cursor;
        w_fill_id   = r_fill_id;
        w_overrun   = r_overrun;
        w_remaining = r_remaining;
        w_tm_we     = 1'b0;
        w_tm_addr   = r_tm_addr;
        w_tm_data   = r_tm_data;
        w_readdata  = r_readdata;
`ifdef TILE_FILL_STRIDE_EN
        w_stride    = r_stride;
`endif

        // A running sequence issues one write per cycle. The write for the
        // first element was already issued when the command was accepted, so
        // r_remaining counts the writes still to come; when it reaches zero
        // the cycle showing the last write is also the last busy cycle.
        case (r_state)
            ST_IDLE: begin
                w_state = ST_IDLE;
            end
            ST_FILL, ST_CLEAR: begin
                if (r_remaining == '0) begin
                    w_state = ST_IDLE;
                end else begin
                    w_tm_we     = 1'b1;
                    w_tm_addr   = r_cursor;
                    w_tm_data   = (r_state == ST_FILL) ? r_fill_id : BLANK_W;
                    w_cursor    = advance(r_cursor,
                                          (r_state == ST_FILL) ? w_fill_step : 7'd1);
                    w_remaining = r_remaining - ADDR_W'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Bus writes: STATUS_CLR always acts, anything else is dropped while
        // busy (including the final cycle of a sequence).
        if (w_bus_wr && (bus.address == REG_STATUS_CLR)) begin
            w_overrun = 1'b0;
        end else if (w_bus_wr && w_busy) begin
            w_overrun = (bus.address == REG_RESERVED) ? r_overrun : 1'b1;
        end else if (w_bus_wr) begin
            case (bus.address)
                REG_CURSOR: begin
                    w_cursor = (w_count_raw >= TILES_W) ? '0 : w_count_raw;
                end
                REG_TILE: begin
                    w_tm_we   = 1'b1;
                    w_tm_addr = r_cursor;
                    w_tm_data = sanitize_id(bus.writedata);
                    w_cursor  = advance(r_cursor, 7'd1);
                end
                REG_FILL_ID: begin
                    w_fill_id = sanitize_id(bus.writedata);
                end
                REG_FILL_COUNT: begin
                    if (w_count != '0) begin
                        w_tm_we     = 1'b1;
                        w_tm_addr   = r_cursor;
                        w_tm_data   = r_fill_id;
                        w_cursor    = advance(r_cursor, w_fill_step);
                        w_remaining = w_count - ADDR_W'(1);
                        w_state     = ST_FILL;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                REG_CLEAR: begin
                    w_tm_we     = 1'b1;
                    w_tm_addr   = '0;
                    w_tm_data   = BLANK_W;
                    w_cursor    = advance('0, 7'd1);
                    w_remaining = TILES_W - ADDR_W'(1);
                    w_state     = ST_CLEAR;
                end
                REG_STRIDE: begin
`ifdef TILE_FILL_STRIDE_EN
                    w_stride = ((w_stride_in == 7'd0) || (w_stride_in > 7'd80))
                               ? 7'd1 : w_stride_in;
`else
                    w_overrun = r_overrun;
`endif
                end
                default: begin
                    w_overrun = r_overrun;
                end
            endcase
        end else begin
            w_overrun = r_overrun;
        end

        // Status snapshot of the current cycle, captured on a read.
        if (w_bus_rd) begin
            w_readdata = {w_busy, r_overrun, 1'b0, r_cursor};
        end else begin
            w_readdata = r_readdata;
        end
    end

    // State and output registers; reset restarts the map clear. r_remaining
    // starts at NUM_TILES (not NUM_TILES-1) because no write is issued on the
    // reset edge itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_cursor    <= '0;
            r_fill_id   <= BLANK_W;
            r_overrun   <= 1'b0;
            r_remaining <= TILES_W;
            r_tm_we     <= 1'b0;
            r_tm_addr   <= '0;
            r_tm_data   <= BLANK_W;
            r_readdata  <= 16'd0;
`ifdef TILE_FILL_STRIDE_EN
            r_stride    <= 7'd1;
`endif
        end else begin
            r_state     <= w_state;
            r_cursor    <= w_cursor;
            r_fill_id   <= w_fill_id;
            r_overrun   <= w_overrun;
            r_remaining <= w_remaining;
            r_tm_we     <= w_tm_we;
            r_tm_addr   <= w_tm_addr;
            r_tm_data   <= w_tm_data;
            r_readdata  <= w_readdata;
`ifdef TILE_FILL_STRIDE_EN
            r_stride    <= w_stride;
`endif
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.tm_we    = r_tm_we;
    assign bus.tm_addr  = r_tm_addr;
    assign bus.tm_data  = r_tm_data;
    assign bus.busy     = w_busy;

endmodule

// File: tb/tb_tile_map_writer.sv
// -----------------------------------------------------------------------------
// tb_tile_map_writer
// Self-checking bench for tile_map_writer: table of single-tile vectors,
// hand-written multi-cycle sequences (post-reset clear, fill with dropped
// writes, reset abort, stride fill) and randomized bus traffic, all checked
// against a queue-based reference model of the register behaviour.
// -----------------------------------------------------------------------------
module tb_tile_map_writer;

    localparam int NT    = 4800;
    localparam int BLANK = 37;

    typedef struct packed {
        logic [12:0] addr;
        logic [5:0]  data;
    } wr_t;

    typedef struct {
        logic        do_load;
        logic [15:0] cur_load;
        logic [15:0] tile;
        int          exp_addr;
        int          exp_data;
        int          exp_cursor;
    } tile_vec_t;

    logic clk = 1'b0;
    logic reset;

    tile_map_writer_if bus_if ();

    tile_map_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    wr_t         exp_q[$];
    int          m_cursor;
    int          m_fill_id;
    logic        m_overrun;
    int          m_stride;
    int          m_busy_left;
    int          m_skip;
    logic        rd_chk;
    logic        rd_cur_known;
    logic [15:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int san(input int v);
        return (v >= 38) ? BLANK : v;
    endfunction

    // Applies the register rules to the inputs present before the coming edge.
    task automatic model_edge();
        logic cur_busy;
        int   d;
        int   n;
        cur_busy = (m_busy_left > 0);
        rd_chk   = 1'b0;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < NT; i++) exp_q.push_back(wr_t'{13'(i), 6'(BLANK)});
            m_cursor = 0; m_fill_id = BLANK; m_overrun = 1'b0; m_stride = 1;
            m_busy_left = NT + 1; m_skip = 1;
            rd_chk = 1'b1; rd_cur_known = 1'b1; m_rd = 16'd0;
            return;
        end
        if (bus_if.chipselect && bus_if.read) begin
            rd_chk       = 1'b1;
            rd_cur_known = !cur_busy;
            m_rd         = {cur_busy, m_overrun, 1'b0, 13'(m_cursor)};
        end
        if (m_busy_left > 0) m_busy_left--;
        if (bus_if.chipselect && bus_if.write) begin
            d = int'(bus_if.writedata);
            if (bus_if.address == 3'd5) m_overrun = 1'b0;
            else if (cur_busy) begin
                if (bus_if.address != 3'd7) m_overrun = 1'b1;
            end else begin
                case (bus_if.address)
                    3'd0: m_cursor = ((d % 8192) >= NT) ? 0 : (d % 8192);
                    3'd1: begin
                        exp_q.push_back(wr_t'{13'(m_cursor), 6'(san(d))});
                        m_cursor = (m_cursor + 1) % NT;
                    end
                    3'd2: m_fill_id = san(d);
                    3'd3: begin
                        n = d % 8192;
                        if (n > NT) n = NT;
                        for (int i = 0; i < n; i++)
                            exp_q.push_back(wr_t'{13'((m_cursor + i * m_stride) % NT), 6'(m_fill_id)});
                        m_cursor    = (m_cursor + n * m_stride) % NT;
                        m_busy_left = n;
                    end
                    3'd4: begin
                        for (int i = 0; i < NT; i++) exp_q.push_back(wr_t'{13'(i), 6'(BLANK)});
                        m_cursor    = 0;
                        m_busy_left = NT;
                    end
`ifdef TILE_FILL_STRIDE_EN
                    3'd6: m_stride = (((d % 128) == 0) || ((d % 128) > 80)) ? 1 : (d % 128);
`endif
                    default: ;
                endcase
            end
        end
    endtask

    // Compares DUT outputs just after the edge against the model.
    task automatic model_check();
        logic exp_we;
        wr_t  e;
        exp_we = (m_skip == 0) && (exp_q.size() > 0);
        if (m_skip > 0) m_skip--;
        check("m_tm_we", bus_if.tm_we, exp_we);
        if (exp_we) begin
            e = exp_q.pop_front();
            check("m_tm_addr", bus_if.tm_addr, e.addr);
            check("m_tm_data", bus_if.tm_data, e.data);
        end
        check("m_busy", bus_if.busy, m_busy_left > 0);
        if (rd_chk) begin
            if (rd_cur_known) check("m_readdata", bus_if.readdata, m_rd);
            else check("m_rd_flags", bus_if.readdata[15:13], m_rd[15:13]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic idle_bus();
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.read       = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.writedata  = 16'd0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.read       = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        step();
        idle_bus();
    endtask

    task automatic bus_read();
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.write      = 1'b0;
        step();
        idle_bus();
    endtask

    task automatic wait_idle(input int limit, input string name);
        for (int i = 0; i < limit && bus_if.busy; i++) step();
        check(name, bus_if.busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tile_vec_t vecs[9];
        int n_wr, first_wr, last_wr, fall;
        int st_addr[3];
        int st_cur;
        int clears_left;

        idle_bus();
        reset = 1'b0;

        // ---------------- reset and post-reset clear ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_tm_we",   bus_if.tm_we,    1'b0);
        check("rst_tm_addr", bus_if.tm_addr,  13'd0);
        check("rst_tm_data", bus_if.tm_data,  6'd37);
        check("rst_busy",    bus_if.busy,     1'b1);
        check("rst_rdata",   bus_if.readdata, 16'd0);
        n_wr = 0; first_wr = -1; last_wr = -1; fall = -1;
        for (int c = 1; c <= NT + 10 && fall < 0; c++) begin
            step();
            if (bus_if.tm_we) begin
                n_wr++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
            end
            if (!bus_if.busy) fall = c;
        end
        check("clr_writes",    n_wr, NT);
        check("clr_first_wr",  first_wr, 1);
        check("clr_busy_fall", fall, last_wr + 1);
        bus_read();
        check("clr_cursor", bus_if.readdata, 16'd0);

        // ---------------- single tile vectors ----------------
        vecs[0] = '{1'b1, 16'd4799,  16'd5,  4799, 5,  0};
        vecs[1] = '{1'b0, 16'd0,     16'd6,  0,    6,  1};
        vecs[2] = '{1'b0, 16'd0,     16'd50, 1,    37, 2};
        vecs[3] = '{1'b1, 16'd5000,  16'd12, 0,    12, 1};
        vecs[4] = '{1'b1, 16'd4800,  16'd36, 0,    36, 1};
        vecs[5] = '{1'b1, 16'd2400,  16'd37, 2400, 37, 2401};
        vecs[6] = '{1'b1, 16'd4798,  16'd38, 4798, 37, 4799};
        vecs[7] = '{1'b1, 16'd8191,  16'd0,  0,    0,  1};
        vecs[8] = '{1'b1, 16'h2005,  16'd7,  5,    7,  6};
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].do_load) bus_write(3'd0, vecs[v].cur_load);
            bus_write(3'd1, vecs[v].tile);
            check("tile_we",   bus_if.tm_we,   1'b1);
            check("tile_addr", bus_if.tm_addr, vecs[v].exp_addr);
            check("tile_data", bus_if.tm_data, vecs[v].exp_data);
            bus_read();
            check("tile_cursor", bus_if.readdata, vecs[v].exp_cursor);
        end

        // ---------------- fill with a dropped write ----------------
        bus_write(3'd0, 16'd1227);
        bus_write(3'd2, 16'd1);
        bus_write(3'd3, 16'd12);
        for (int i = 0; i < 12; i++) begin
            check("fill_we",   bus_if.tm_we,   1'b1);
            check("fill_addr", bus_if.tm_addr, 1227 + i);
            check("fill_data", bus_if.tm_data, 6'd1);
            check("fill_busy", bus_if.busy,    1'b1);
            if (i == 3) bus_write(3'd1, 16'd3);
            else step();
        end
        check("fill_end_we",   bus_if.tm_we, 1'b0);
        check("fill_end_busy", bus_if.busy,  1'b0);
        bus_read();
        check("fill_overrun", bus_if.readdata, 16'h4000 | 16'd1239);
        bus_write(3'd5, 16'd0);
        bus_read();
        check("stsclr", bus_if.readdata, 16'd1239);
        bus_write(3'd3, 16'd0);
        check("fill0_we",   bus_if.tm_we, 1'b0);
        check("fill0_busy", bus_if.busy,  1'b0);
        // write landing on the last fill cycle is still dropped
        bus_write(3'd3, 16'd2);
        step();
        check("last_busy", bus_if.busy, 1'b1);
        bus_write(3'd1, 16'd5);
        check("last_drop_we", bus_if.tm_we, 1'b0);
        bus_read();
        check("last_drop_ovr", bus_if.readdata, 16'h4000 | 16'd1241);
        bus_write(3'd5, 16'd0);

        // ---------------- reset aborts a fill ----------------
        bus_write(3'd0, 16'd0);
        bus_write(3'd3, 16'd100);
        for (int i = 2; i <= 10; i++) begin
            if (i == 2) bus_write(3'd0, 16'd55);
            else if (i == 3) begin
                bus_read();
                check("abort_rd_flags", bus_if.readdata[15:14], 2'b11);
            end else step();
        end
        check("abort_pre_addr", bus_if.tm_addr, 13'd9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_we",   bus_if.tm_we,   1'b0);
        check("abort_busy", bus_if.busy,    1'b1);
        check("abort_data", bus_if.tm_data, 6'd37);
        step();
        check("abort_clr_we",   bus_if.tm_we,   1'b1);
        check("abort_clr_addr", bus_if.tm_addr, 13'd0);
        wait_idle(NT + 10, "abort_idle");
        bus_read();
        check("abort_status", bus_if.readdata, 16'd0);

        // ---------------- stride fill ----------------
`ifdef TILE_FILL_STRIDE_EN
        st_addr[0] = 4720; st_addr[1] = 0; st_addr[2] = 80; st_cur = 160;
`else
        st_addr[0] = 4720; st_addr[1] = 4721; st_addr[2] = 4722; st_cur = 4723;
`endif
        bus_write(3'd0, 16'd4720);
        bus_write(3'd6, 16'd80);
        bus_write(3'd2, 16'd9);
        bus_write(3'd3, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check("stride_we",   bus_if.tm_we,   1'b1);
            check("stride_addr", bus_if.tm_addr, st_addr[i]);
            check("stride_data", bus_if.tm_data, 6'd9);
            step();
        end
        bus_read();
        check("stride_cursor", bus_if.readdata, st_cur);
        bus_write(3'd6, 16'd0);

        // ---------------- randomized traffic ----------------
        clears_left = 1;
        for (int k = 0; k < 2500; k++) begin
            int          a;
            logic [15:0] d;
            a = $urandom_range(0, 7);
            if (a == 4) begin
                if (clears_left > 0) clears_left--;
                else a = 3;
            end
            case (a)
                0:       d = 16'($urandom);
                1, 2:    d = 16'($urandom_range(0, 63));
                3:       d = 16'($urandom_range(0, 40));
                6:       d = 16'($urandom_range(0, 127));
                default: d = 16'($urandom);
            endcase
            bus_if.address    = 3'(a);
            bus_if.writedata  = d;
            bus_if.write      = ($urandom_range(0, 2) != 0);
            bus_if.read       = ($urandom_range(0, 2) == 0);
            bus_if.chipselect = ($urandom_range(0, 7) != 0);
            step();
        end
        idle_bus();
        wait_idle(NT + 10, "rand_idle");
        bus_read();
        check("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
